// File: rtl/layer_output_serializer.sv
// Layer output serializer: captures a layer's parallel neuron outputs and
// streams them one per cycle while tracking the signed argmax.
module layer_output_serializer #(
  parameter int numNeurons = 30,
  parameter int dataWidth  = 16,
  localparam int IW = (numNeurons > 1) ? $clog2(numNeurons) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [numNeurons*dataWidth-1:0] x_in,
  input  logic                            x_valid,
  output logic [dataWidth-1:0]            out,
  output logic                            out_valid,
  output logic                            out_last,
  output logic                            busy,
  output logic                            overrun,
  output logic [IW-1:0]                   max_idx,
  output logic [dataWidth-1:0]            max_val,
  output logic                            max_valid
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [IW-1:0] LAST = IW'(numNeurons - 1);

  state_t               state_q, state_d;
  logic [IW-1:0]        cnt_q, cnt_d;
  logic [dataWidth-1:0] buf_q [numNeurons];
  logic [dataWidth-1:0] buf_d [numNeurons];
  logic [dataWidth-1:0] out_q, out_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic                 busy_q, busy_d;
  logic                 overrun_q, overrun_d;
  logic [dataWidth-1:0] run_max_q, run_max_d;
  logic [IW-1:0]        run_idx_q, run_idx_d;
  logic [IW-1:0]        max_idx_q, max_idx_d;
  logic [dataWidth-1:0] max_val_q, max_val_d;
  logic                 max_valid_q, max_valid_d;

  logic                 take;
  logic                 accept;
  logic [IW-1:0]        nxt;
  logic [dataWidth-1:0] cur_max;
  logic [IW-1:0]        cur_idx;

  // Element 0 seeds the running max; later ones win only if strictly greater
  assign take    = (cnt_q == '0) ||
                   ($signed(out_q) > $signed(run_max_q));
  assign cur_max = take ? out_q : run_max_q;
  assign cur_idx = take ? cnt_q : run_idx_q;
  assign nxt     = cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    busy_d      = 1'b0;
    overrun_d   = overrun_q;
    run_max_d   = run_max_q;
    run_idx_d   = run_idx_q;
    max_idx_d   = max_idx_q;
    max_val_d   = max_val_q;
    max_valid_d = 1'b0;
    accept      = 1'b0;

    unique case (state_q)
      IDLE: begin
        accept = x_valid;
      end
      SEND: begin
        run_max_d = cur_max;
        run_idx_d = cur_idx;
        if (out_last_q) begin
          max_idx_d   = cur_idx;
          max_val_d   = cur_max;
          max_valid_d = 1'b1;
          state_d     = IDLE;
          accept      = x_valid;
        end else begin
          if (x_valid) overrun_d = 1'b1;
          cnt_d       = nxt;
          out_d       = buf_q[nxt];
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
          out_last_d  = (nxt == LAST);
        end
      end
      default: state_d = IDLE;
    endcase

    // Element 0 goes straight to out so the stream starts next cycle
    if (accept) begin
      for (int k = 0; k < numNeurons; k++) begin
        buf_d[k] = x_in[k*dataWidth +: dataWidth];
      end
      cnt_d       = '0;
      out_d       = x_in[0 +: dataWidth];
      out_valid_d = 1'b1;
      busy_d      = 1'b1;
      out_last_d  = (numNeurons == 1);
      state_d     = SEND;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      for (int k = 0; k < numNeurons; k++) begin
        buf_q[k] <= '0;
      end
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      run_max_q   <= '0;
      run_idx_q   <= '0;
      max_idx_q   <= '0;
      max_val_q   <= '0;
      max_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      run_max_q   <= run_max_d;
      run_idx_q   <= run_idx_d;
      max_idx_q   <= max_idx_d;
      max_val_q   <= max_val_d;
      max_valid_q <= max_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;
  assign max_idx   = max_idx_q;
  assign max_val   = max_val_q;
  assign max_valid = max_valid_q;

endmodule

// File: doc/layer_output_serializer.md
Name: layer_output_serializer

Overview:
- Sits directly downstream of one layer's array of neuron instances.
- Captures the layer's parallel neuron outputs in one cycle, then streams them one element per cycle as the data/valid pair that feeds the next layer's neuron inputs (myinput/myinputValid).
- Also tracks the running signed maximum and its index, so the same block serves as the final-layer classifier.

Parameters:
- numNeurons, 30, number of neurons in the producing layer (≥1).
- dataWidth, 16, width of each neuron output / stream element (two's complement).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- x_in  input  numNeurons*dataWidth  packed neuron outputs; neuron k occupies bits [k*dataWidth +: dataWidth].
- x_valid  input  1  one-cycle pulse: all of x_in valid (driven by neuron 0 outvalid).
- out  output  dataWidth  current stream element.
- out_valid  output  1  out is valid this cycle.
- out_last  output  1  high with element numNeurons-1.
- busy  output  1  frame being streamed.
- overrun  output  1  sticky: a frame was dropped.
- max_idx  output  $clog2(numNeurons) (min 1)  index of largest element of the last completed frame.
- max_val  output  dataWidth  value of that element.
- max_valid  output  1  one-cycle pulse: max_idx/max_val updated.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; out, out_valid, out_last, busy, overrun, max_idx, max_val, max_valid all 0; counter 0. Asserting reset mid-frame aborts the frame immediately. No partial max_valid is produced.
- States:
  - IDLE: x_valid=1 sampled at edge E0 → load x_in into the internal buffer, counter=0, go to SEND.
  - SEND: element k is presented on out with out_valid=1 during the k-th cycle after E0 (k=0..numNeurons-1), so elements appear in index order, neuron 0 first.
- Flags during SEND:
  - out_last=1 only in the cycle of element numNeurons-1.
  - busy=1 from the cycle after E0 through the out_last cycle inclusive.
- After the out_last cycle, return to IDLE. out_valid and out_last are 0 and out holds its last value.
- Back-to-back frames: x_valid sampled on the edge that ends the out_last cycle is accepted. Element 0 of the new frame follows with no gap cycle.
- Overrun: x_valid=1 while busy in any cycle other than the out_last cycle is ignored. The buffer and stream are unchanged, and overrun is set to 1 and held until reset.
- numNeurons=1: a single cycle with out_valid=out_last=busy=1.
- Argmax:
  - Signed compare on each emitted element; element 0 initializes the running max.
  - A later element replaces the running max only if strictly greater, so ties keep the lower index.
  - On the edge ending the out_last cycle, max_idx and max_val are registered and max_valid pulses for exactly the next cycle.
  - max_idx and max_val hold until the next max_valid.
- All outputs are registered. Latency from the x_valid edge to the first out_valid cycle is 1 cycle. A full frame occupies exactly numNeurons cycles.
- Upstream contract: x_valid is a single-cycle pulse per frame. Holding it high is treated as repeated frames, and overrun rules apply.

Test Plan (numNeurons=4, dataWidth=16; e0..e3 denote x_in slices 0..3):
- Reset: assert rst=0 mid-cycle → all outputs 0 immediately. Release → outputs stay 0 with no x_valid.
- Single frame e0=0x0020, e1=0x0100, e2=0xFFF0, e3=0x0004, x_valid 1 cycle:
  - out = 0x0020, 0x0100, 0xFFF0, 0x0004 in cycles 1-4 after capture.
  - out_last only in cycle 4; busy high cycles 1-4.
  - max_valid in cycle 5 with max_idx=1, max_val=0x0100.
- Back-to-back: second frame e0..e3=0x0001, 0x0002, 0x0003, 0x0004 with x_valid in the first frame's out_last cycle:
  - 8 consecutive out_valid cycles, no gap.
  - Second max_valid gives max_idx=3, max_val=0x0004; overrun stays 0.
- Overrun: x_valid pulse during the element-1 cycle → stream unchanged (first frame's four values), overrun=1 and held until reset.
- Ties/negative: e0=0x8000, e1=0xFFFF, e2=0xFFFF, e3=0x8000 → max_idx=1, max_val=0xFFFF.
- Abort: rst=0 during the element-1 cycle → out_valid, busy, out_last drop to 0 immediately and no max_valid follows. After release, a new frame streams and reports argmax correctly.
